// File: rtl/exc_ctrl.sv
// Exception/interrupt controller between MEM and CP0: prioritises sources,
// waits for the data bus, pulses one commit code with flush, then redirects fetch.
`ifndef EXC_TYPE_DEFS
`define EXC_TYPE_DEFS
`define EXC_TYPE_BUS  4:0
`define EXC_TYPE_NONE 5'd0
`define EXC_TYPE_INT  5'd1
`define EXC_TYPE_IF   5'd2
`define EXC_TYPE_RI   5'd3
`define EXC_TYPE_OV   5'd4
`define EXC_TYPE_BP   5'd5
`define EXC_TYPE_SYS  5'd6
`define EXC_TYPE_ADEL 5'd7
`define EXC_TYPE_ADES 5'd8
`define EXC_TYPE_ERET 5'd9
`endif

module exc_ctrl #(
    parameter int unsigned         ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]   EXC_VECTOR = ADDR_W'(32'hBFC00380)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid_i,
    input  logic [ADDR_W-1:0]     mem_pc_i,
    input  logic                  mem_in_delayslot_i,
    input  logic [ADDR_W-1:0]     mem_badaddr_i,
    input  logic                  exc_if_i,
    input  logic                  exc_ri_i,
    input  logic                  exc_ov_i,
    input  logic                  exc_bp_i,
    input  logic                  exc_sys_i,
    input  logic                  exc_adel_i,
    input  logic                  exc_ades_i,
    input  logic                  eret_i,
    input  logic [ADDR_W-1:0]     status_i,
    input  logic [ADDR_W-1:0]     cause_i,
    input  logic [ADDR_W-1:0]     epc_i,
    input  logic                  data_busy_i,
    input  logic                  pc_ready_i,
    output logic [`EXC_TYPE_BUS]  exception_type_o,
    output logic [ADDR_W-1:0]     cp0_pc_o,
    output logic                  cp0_delayslot_o,
    output logic [ADDR_W-1:0]     cp0_badvaddr_o,
    output logic                  stall_o,
    output logic                  flush_o,
    output logic                  redirect_valid_o,
    output logic [ADDR_W-1:0]     new_pc_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BUS = 2'd1,
        FLUSH    = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    state_t state, state_next;

    logic [`EXC_TYPE_BUS] code_q;
    logic [ADDR_W-1:0]    pc_q;
    logic                 ds_q;
    logic [ADDR_W-1:0]    badv_q;
    logic [ADDR_W-1:0]    tgt_q;

    logic                 int_pend;
    logic                 any_src;
    logic                 detect;
    logic [`EXC_TYPE_BUS] det_code;
    logic [ADDR_W-1:0]    det_badv;
    logic [ADDR_W-1:0]    det_tgt;

    // Status/Cause bits outside IE/EXL/IM/IP play no role here
    logic unused_bits;
    assign unused_bits = ^{status_i[ADDR_W-1:16], status_i[7:2],
                           cause_i[ADDR_W-1:16], cause_i[7:0]};

    assign int_pend = status_i[0] & ~status_i[1] & (|(cause_i[15:8] & status_i[15:8]));
    assign any_src  = int_pend | exc_if_i | exc_ri_i | exc_ov_i | exc_bp_i
                    | exc_sys_i | exc_adel_i | exc_ades_i | eret_i;
    assign detect   = reset & (state == IDLE) & mem_valid_i & any_src;

    // Fixed-priority source selection and badvaddr/target choice
    always_comb begin
        det_code = `EXC_TYPE_NONE;
        det_badv = '0;
        det_tgt  = EXC_VECTOR;
        if (int_pend)        det_code = `EXC_TYPE_INT;
        else if (exc_if_i)   begin det_code = `EXC_TYPE_IF;   det_badv = mem_pc_i;      end
        else if (exc_ri_i)   det_code = `EXC_TYPE_RI;
        else if (exc_ov_i)   det_code = `EXC_TYPE_OV;
        else if (exc_bp_i)   det_code = `EXC_TYPE_BP;
        else if (exc_sys_i)  det_code = `EXC_TYPE_SYS;
        else if (exc_adel_i) begin det_code = `EXC_TYPE_ADEL; det_badv = mem_badaddr_i; end
        else if (exc_ades_i) begin det_code = `EXC_TYPE_ADES; det_badv = mem_badaddr_i; end
        else if (eret_i)     begin det_code = `EXC_TYPE_ERET; det_tgt  = epc_i;         end
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // Commit context is captured only at detection and frozen until the next one
    always_ff @(posedge clk) begin
        if (!reset) begin
            code_q <= `EXC_TYPE_NONE;
            pc_q   <= '0;
            ds_q   <= 1'b0;
            badv_q <= '0;
            tgt_q  <= '0;
        end else if (detect) begin
            code_q <= det_code;
            pc_q   <= mem_pc_i;
            ds_q   <= mem_in_delayslot_i;
            badv_q <= det_badv;
            tgt_q  <= det_tgt;
        end
    end

    always_comb begin
        state_next       = state;
        exception_type_o = `EXC_TYPE_NONE;
        cp0_pc_o         = '0;
        cp0_delayslot_o  = 1'b0;
        cp0_badvaddr_o   = '0;
        stall_o          = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        new_pc_o         = '0;
        case (state)
            IDLE: begin
                stall_o = detect;
                if (detect) state_next = data_busy_i ? WAIT_BUS : FLUSH;
            end
            WAIT_BUS: begin
                stall_o = 1'b1;
                if (!data_busy_i) state_next = FLUSH;
            end
            FLUSH: begin
                exception_type_o = code_q;
                cp0_pc_o         = pc_q;
                cp0_delayslot_o  = ds_q;
                cp0_badvaddr_o   = badv_q;
                flush_o          = 1'b1;
                stall_o          = 1'b1;
                state_next       = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid_o = 1'b1;
                new_pc_o         = tgt_q;
                stall_o          = 1'b1;
                if (pc_ready_i) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// Bench for exc_ctrl: directed vector table, multi-cycle corner sequences,
// and randomized traffic checked against a transaction-level reference model.
module tb_exc_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam logic [4:0] C_NONE = 5'd0, C_INT = 5'd1, C_IF = 5'd2, C_RI = 5'd3,
                           C_OV = 5'd4, C_BP = 5'd5, C_SYS = 5'd6, C_ADEL = 5'd7,
                           C_ADES = 5'd8, C_ERET = 5'd9;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, mem_ds;
    logic [31:0] mem_pc, mem_badaddr, status, cause, epc;
    logic        f_if, f_ri, f_ov, f_bp, f_sys, f_adel, f_ades, f_eret;
    logic        data_busy, pc_ready;
    logic [4:0]  exception_type;
    logic [31:0] cp0_pc, cp0_badvaddr, new_pc;
    logic        cp0_delayslot, stall, flush, redirect_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    exc_ctrl dut (
        .clk(clk), .reset(reset),
        .mem_valid_i(mem_valid), .mem_pc_i(mem_pc), .mem_in_delayslot_i(mem_ds),
        .mem_badaddr_i(mem_badaddr),
        .exc_if_i(f_if), .exc_ri_i(f_ri), .exc_ov_i(f_ov), .exc_bp_i(f_bp),
        .exc_sys_i(f_sys), .exc_adel_i(f_adel), .exc_ades_i(f_ades), .eret_i(f_eret),
        .status_i(status), .cause_i(cause), .epc_i(epc),
        .data_busy_i(data_busy), .pc_ready_i(pc_ready),
        .exception_type_o(exception_type), .cp0_pc_o(cp0_pc),
        .cp0_delayslot_o(cp0_delayslot), .cp0_badvaddr_o(cp0_badvaddr),
        .stall_o(stall), .flush_o(flush),
        .redirect_valid_o(redirect_valid), .new_pc_o(new_pc)
    );

    // Reference model: a commit is "pending" (waiting for bus), "committing"
    // (the one-cycle CP0 pulse) or "redirecting" (waiting for fetch).
    bit          m_pending, m_commit, m_redirect;
    logic [4:0]  m_code;
    logic [31:0] m_pc, m_badv, m_tgt;
    logic        m_ds;

    function automatic bit m_busy_any();
        return m_pending || m_commit || m_redirect;
    endfunction

    function automatic logic [4:0] m_winner();
        bit srcs [9];
        bit ip;
        ip = status[0] && !status[1] && (((cause >> 8) & (status >> 8) & 32'hFF) != 0);
        srcs = '{ip, f_if, f_ri, f_ov, f_bp, f_sys, f_adel, f_ades, f_eret};
        for (int i = 0; i < 9; i++)
            if (srcs[i]) return 5'(i + 1);
        return C_NONE;
    endfunction

    function automatic bit m_detect();
        return reset && !m_busy_any() && mem_valid && (m_winner() != C_NONE);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("m_code",  32'(exception_type), m_commit ? 32'(m_code) : 32'(C_NONE));
        chk("m_flush", 32'(flush), 32'(m_commit));
        chk("m_cp0pc", cp0_pc, m_commit ? m_pc : 32'h0);
        chk("m_cp0ds", 32'(cp0_delayslot), m_commit ? 32'(m_ds) : 32'h0);
        chk("m_badv",  cp0_badvaddr, m_commit ? m_badv : 32'h0);
        chk("m_redir", 32'(redirect_valid), 32'(m_redirect));
        chk("m_newpc", new_pc, m_redirect ? m_tgt : 32'h0);
        chk("m_stall", 32'(stall), 32'(m_busy_any() || m_detect()));
    endtask

    task automatic model_advance();
        logic [4:0] w;
        if (!reset) begin
            m_pending = 0; m_commit = 0; m_redirect = 0;
        end else if (m_detect()) begin
            w      = m_winner();
            m_code = w;
            m_pc   = mem_pc;
            m_ds   = mem_ds;
            m_badv = (w == C_IF) ? mem_pc : ((w == C_ADEL || w == C_ADES) ? mem_badaddr : 32'h0);
            m_tgt  = (w == C_ERET) ? epc : VEC;
            m_pending = data_busy;
            m_commit  = !data_busy;
        end else if (m_pending) begin
            if (!data_busy) begin m_pending = 0; m_commit = 1; end
        end else if (m_commit) begin
            m_commit = 0; m_redirect = 1;
        end else if (m_redirect) begin
            if (pc_ready) m_redirect = 0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic set_flags(input logic [7:0] f);
        {f_if, f_ri, f_ov, f_bp, f_sys, f_adel, f_ades, f_eret} = f;
    endtask

    task automatic quiet();
        mem_valid = 0; set_flags(8'h0); status = 0; cause = 0;
    endtask

    typedef struct {
        logic [7:0]  flags;   // {if,ri,ov,bp,sys,adel,ades,eret}
        logic [31:0] status;
        logic [31:0] cause;
        logic [31:0] pc;
        logic [31:0] badaddr;
        logic [31:0] epc;
        logic        ds;
        logic [4:0]  exp_code;
        logic [31:0] exp_badv;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vt [8];

    initial begin
        vt[0] = '{8'h20, 32'h0,   32'h0,   32'h80001000, 32'h0,        32'h0,        1'b0, C_OV,   32'h0,        VEC};
        vt[1] = '{8'h08, 32'h401, 32'h400, 32'h80001100, 32'h0,        32'h0,        1'b1, C_INT,  32'h0,        VEC};
        vt[2] = '{8'h08, 32'h403, 32'h400, 32'h80001200, 32'h0,        32'h0,        1'b0, C_SYS,  32'h0,        VEC};
        vt[3] = '{8'h01, 32'h0,   32'h0,   32'h80001300, 32'h0,        32'h80003000, 1'b0, C_ERET, 32'h0,        32'h80003000};
        vt[4] = '{8'hC0, 32'h0,   32'h0,   32'h80004000, 32'h0,        32'h0,        1'b1, C_IF,   32'h80004000, VEC};
        vt[5] = '{8'h06, 32'h0,   32'h0,   32'h80001400, 32'h80005001, 32'h0,        1'b0, C_ADEL, 32'h80005001, VEC};
        vt[6] = '{8'h11, 32'h0,   32'h0,   32'h80001500, 32'h0,        32'h80009000, 1'b0, C_BP,   32'h0,        VEC};
        vt[7] = '{8'h60, 32'h0,   32'h0,   32'h80001600, 32'h0,        32'h0,        1'b0, C_RI,   32'h0,        VEC};

        reset = 0; quiet(); mem_pc = 0; mem_ds = 0; mem_badaddr = 0; epc = 0;
        data_busy = 0; pc_ready = 1;
        m_pending = 0; m_commit = 0; m_redirect = 0;
        m_code = 0; m_pc = 0; m_ds = 0; m_badv = 0; m_tgt = 0;
        tick(); tick();
        chk("rst_code",  32'(exception_type), 32'(C_NONE));
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_redir", 32'(redirect_valid), 32'h0);
        reset = 1;
        tick();

        // Directed vector table: detect -> FLUSH -> REDIRECT -> IDLE
        for (int i = 0; i < 8; i++) begin
            set_flags(vt[i].flags); status = vt[i].status; cause = vt[i].cause;
            mem_pc = vt[i].pc; mem_badaddr = vt[i].badaddr; epc = vt[i].epc;
            mem_ds = vt[i].ds; mem_valid = 1; data_busy = 0; pc_ready = 1;
            #1 chk("v_det_stall", 32'(stall), 32'h1);
            tick();
            quiet();
            #1;
            chk("v_code",  32'(exception_type), 32'(vt[i].exp_code));
            chk("v_flush", 32'(flush), 32'h1);
            chk("v_pc",    cp0_pc, vt[i].pc);
            chk("v_ds",    32'(cp0_delayslot), 32'(vt[i].ds));
            chk("v_badv",  cp0_badvaddr, vt[i].exp_badv);
            tick();
            chk("v_redir", 32'(redirect_valid), 32'h1);
            chk("v_newpc", new_pc, vt[i].exp_tgt);
            chk("v_code0", 32'(exception_type), 32'(C_NONE));
            tick();
            chk("v_idle",  32'(stall), 32'h0);
        end

        // ADES while the data bus stays busy for three cycles
        set_flags(8'h02); mem_badaddr = 32'h80002003; mem_pc = 32'h80002000;
        mem_valid = 1; data_busy = 1;
        tick();
        quiet(); status = 32'h401; cause = 32'h400; mem_valid = 1;  // late interrupt must be ignored
        for (int k = 0; k < 2; k++) begin
            #1 chk("wb_stall", 32'(stall), 32'h1);
            chk("wb_noflush", 32'(flush), 32'h0);
            tick();
        end
        quiet(); data_busy = 0;
        #1 chk("wb_noflush2", 32'(flush), 32'h0);
        tick();
        chk("wb_flush", 32'(flush), 32'h1);
        chk("wb_code",  32'(exception_type), 32'(C_ADES));
        chk("wb_badv",  cp0_badvaddr, 32'h80002003);
        tick(); tick();

        // Redirect held while fetch is not ready
        set_flags(8'h20); mem_pc = 32'h80007000; mem_valid = 1; pc_ready = 0;
        tick(); quiet(); tick();
        for (int k = 0; k < 2; k++) begin
            chk("hold_redir", 32'(redirect_valid), 32'h1);
            chk("hold_newpc", new_pc, VEC);
            tick();
        end
        pc_ready = 1;
        tick();
        chk("hold_done", 32'(redirect_valid), 32'h0);
        chk("hold_stall", 32'(stall), 32'h0);

        // Reset while waiting for the bus kills the commit
        set_flags(8'h08); mem_pc = 32'h80008000; mem_valid = 1; data_busy = 1;
        tick(); quiet();
        reset = 0;
        tick();
        reset = 1; data_busy = 0;
        #1 chk("rs_stall", 32'(stall), 32'h0);
        chk("rs_code", 32'(exception_type), 32'(C_NONE));
        tick();
        chk("rs_noflush", 32'(flush), 32'h0);
        chk("rs_noredir", 32'(redirect_valid), 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset       = ($urandom_range(0, 99) >= 2);
            mem_valid   = $urandom_range(0, 1);
            mem_pc      = $urandom;
            mem_ds      = $urandom_range(0, 1);
            mem_badaddr = $urandom;
            epc         = $urandom;
            for (int b = 0; b < 8; b++) begin
                logic [7:0] f;
                f = {f_if, f_ri, f_ov, f_bp, f_sys, f_adel, f_ades, f_eret};
                f[b] = ($urandom_range(0, 9) == 0);
                set_flags(f);
            end
            status      = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 65535));
            if ($urandom_range(0, 1) == 1) status[1] = 1'b0;
            cause       = $urandom_range(0, 3) == 0 ? 32'($urandom) : 32'h0;
            data_busy   = ($urandom_range(0, 2) == 0);
            pc_ready    = $urandom_range(0, 1);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
